// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-memory / MMIO responder.
// Optional CYCLES counter is enabled by defining DMEM_MMIO_CYCLES_EN.
package dmem_mmio_pkg;

  localparam int TXDATA_OFS = 0;
  localparam int STATUS_OFS = 1;
  localparam int CYCLES_OFS = 2;

  localparam int STAT_CNT_W     = 8;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_CLR_BIT   = 0;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_TX,
    REG_STAT,
    REG_CYC,
    REG_NONE
  } addr_region_t;

endpackage

// File: rtl/mmio_fifo.sv
// First-word-fall-through outbound stream FIFO.
// Contents are not reset; only pointers and count are.
module mmio_fifo #(
  parameter  int SIZE       = 48,
  parameter  int FIFO_DEPTH = 8,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            push,
  input  logic [SIZE-1:0] din,
  input  logic            pop,
  output logic [SIZE-1:0] dout,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [SIZE-1:0] store [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  // storage write, no reset on data
  always_ff @(posedge CLK) begin
    if (do_push) store[wr_ptr] <= din;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (TXDATA stream, STATUS, CYCLES).
// CYCLES is only built when DMEM_MMIO_CYCLES_EN is defined.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int SIZE       = 48,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int MMIO_BASE  = 'h1000
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            WE,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] WD,
  output logic [SIZE-1:0] RD,
  output logic [SIZE-1:0] OutData,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [SIZE-1:0] RAM_TOP =
    SIZE'(DEPTH);
  localparam logic [SIZE-1:0] TX_ADR =
    SIZE'(MMIO_BASE + TXDATA_OFS);
  localparam logic [SIZE-1:0] ST_ADR =
    SIZE'(MMIO_BASE + STATUS_OFS);
  localparam logic [SIZE-1:0] CY_ADR =
    SIZE'(MMIO_BASE + CYCLES_OFS);

  logic [SIZE-1:0] mem [DEPTH];
  addr_region_t    region;
  logic            push;
  logic            pop;
  logic [SIZE-1:0] f_dout;
  logic [CW-1:0]   f_count;
  logic            f_full;
  logic            f_empty;
  logic [SIZE-1:0] status;
  logic [SIZE-1:0] cyc_rd;

  // classify the CPU address into one region
  always_comb begin
    region = REG_NONE;
    unique case (1'b1)
      (A < RAM_TOP): region = REG_RAM;
      (A == TX_ADR): region = REG_TX;
      (A == ST_ADR): region = REG_STAT;
      (A == CY_ADR): region = REG_CYC;
      default:       region = REG_NONE;
    endcase
  end

  // RAM write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (WE && region == REG_RAM)
      mem[A[AW-1:0]] <= WD;
  end

  assign push     = WE && (region == REG_TX);
  assign OutValid = !f_empty;
  assign OutData  = f_dout;
  assign pop      = OutValid && OutReady;

  mmio_fifo #(
    .SIZE       (SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push),
    .din   (WD),
    .pop   (pop),
    .dout  (f_dout),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  // sticky drop flag, cleared by STATUS write bit 0
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      Overflow <= 1'b0;
    else if (push && f_full && !pop)
      Overflow <= 1'b1;
    else if (WE && region == REG_STAT
             && WD[STAT_CLR_BIT])
      Overflow <= 1'b0;
  end

`ifdef DMEM_MMIO_CYCLES_EN
  logic [SIZE-1:0] cycles;

  // free-running count; a write makes its own cycle zero
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      cycles <= '0;
    else if (WE && region == REG_CYC)
      cycles <= SIZE'(1);
    else
      cycles <= cycles + 1'b1;
  end

  assign cyc_rd = cycles;
`else
  assign cyc_rd = '0;
`endif

  // assemble the STATUS word
  always_comb begin
    status = '0;
    status[STAT_CNT_W-1:0]  = STAT_CNT_W'(f_count);
    status[STAT_EMPTY_BIT]  = f_empty;
    status[STAT_FULL_BIT]   = f_full;
    status[SIZE-1]          = Overflow;
  end

  // combinational read mux
  always_comb begin
    RD = '0;
    unique case (region)
      REG_RAM:  RD = mem[A[AW-1:0]];
      REG_STAT: RD = status;
      REG_CYC:  RD = cyc_rd;
      default:  RD = '0;
    endcase
  end

endmodule
